// File: rtl/mc8051_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc8051_pkg
// Purpose  : Shared definitions for the 8051 bus interface unit with
//            instruction prefetch: default widths/depths and FSM encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc8051_pkg;

   localparam int c_ADDR_W   = 16;
   localparam int c_DATA_W   = 8;
   localparam int c_PF_DEPTH = 2;
   localparam int c_TO_CYC   = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2
   } biu_state_e;

endpackage
`default_nettype wire

// File: rtl/mc8051_pfq.sv
`default_nettype none
// ============================================================================
// Module   : mc8051_pfq
// Purpose  : Prefetch queue - small power-of-two FIFO with flush and count.
//            Pop on empty is ignored; flush wins over push/pop.
// Ports    : clk, reset_n      - clock, async active-low reset
//            push_i / data_i   - write one entry
//            pop_i             - consume head
//            flush_i           - empty the queue
//            data_o / valid_o  - head entry (0 when empty) / not empty
//            count_o           - current fill level
// Revision : 1.0 - initial release
// ============================================================================
module mc8051_pfq #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [DATA_W-1:0]          data_i,
   output logic [DATA_W-1:0]          data_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_q;
   logic [PTR_W-1:0]  wr_q;
   logic [CNT_W-1:0]  cnt_q;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (cnt_q == '0);
   assign w_full  = (cnt_q == CNT_W'(DEPTH));
   assign w_pop   = pop_i && !w_empty;
   // A push into a full queue is accepted only when the head leaves together.
   assign w_push  = push_i && (!w_full || w_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (w_push) wr_q <= wr_q + PTR_W'(1);
         if (w_pop)  rd_q <= rd_q + PTR_W'(1);
         if (w_push && !w_pop)
            cnt_q <= cnt_q + CNT_W'(1);
         else if (!w_push && w_pop)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Storage needs no reset: the head is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (w_push && !flush_i)
         mem_q[wr_q] <= data_i;
   end

   assign data_o  = w_empty ? '0 : mem_q[rd_q];
   assign valid_o = !w_empty;
   assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mc8051_biu_pf.sv
`default_nettype none
// ============================================================================
// Module   : mc8051_biu_pf
// Purpose  : 8051 bus interface unit. Arbitrates data accesses (priority)
//            against instruction prefetch into a small queue and drives
//            registered active-low memory strobes.
// Config   : `define MC8051_BIU_TIMEOUT_EN adds a wait-state timeout that
//            completes a stalled access with all-ones data and o_bus_err.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            i_acc_*/o_acc_*              - data access request/completion
//            i_pc_load, i_pc_addr         - flush queue, restart prefetch
//            i_fetch_pop, o_fetch_*       - prefetch queue head
//            o_bus_err                    - timeout pulse
//            mem_*                        - external memory bus
// Revision : 1.0 - initial release
// ============================================================================
module mc8051_biu_pf
   import mc8051_pkg::*;
#(
   parameter int ADDR_W   = c_ADDR_W,
   parameter int DATA_W   = c_DATA_W,
   parameter int PF_DEPTH = c_PF_DEPTH,
   parameter int TO_CYC   = c_TO_CYC
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_acc_req,
   input  logic              i_acc_we,
   input  logic              i_acc_psen,
   input  logic [ADDR_W-1:0] i_acc_addr,
   input  logic [DATA_W-1:0] i_acc_wdata,
   output logic              o_acc_done,
   output logic [DATA_W-1:0] o_acc_rdata,
   input  logic              i_pc_load,
   input  logic [ADDR_W-1:0] i_pc_addr,
   input  logic              i_fetch_pop,
   output logic              o_fetch_valid,
   output logic [DATA_W-1:0] o_fetch_data,
   output logic              o_bus_err,
   output logic              mem_we_n,
   output logic              mem_rd_n,
   output logic              mem_psen_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_rdy
);

   localparam int CNT_W = $clog2(PF_DEPTH) + 1;

   if (PF_DEPTH < 2 || (PF_DEPTH & (PF_DEPTH - 1)) != 0 || TO_CYC < 1) begin : g_cfg_check
      $error("mc8051_biu_pf: PF_DEPTH must be a power of two >= 2, TO_CYC >= 1");
   end

   biu_state_e        state_q;
   logic              we_n_q, rd_n_q, psen_n_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] pc_q;
   logic              done_q;
   logic [DATA_W-1:0] rdata_q;
   logic              discard_q;   // in-flight fetch was overtaken by a pc load

   logic [CNT_W-1:0]  w_pf_count;
   logic              w_pf_room;
   logic              w_timeout;
   logic              w_complete;
   logic [DATA_W-1:0] w_cap_data;
   logic              w_push;

   // Prefetch only starts from IDLE, where nothing is in flight, so the
   // queue count alone is the occupancy including outstanding fetches.
   assign w_pf_room  = (w_pf_count < CNT_W'(PF_DEPTH));
   assign w_complete = mem_data_rdy || w_timeout;
   assign w_cap_data = w_timeout ? '1 : mem_rdata;
   assign w_push     = (state_q == ST_FETCH) && w_complete && !discard_q && !i_pc_load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         we_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         psen_n_q  <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         pc_q      <= '0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
         discard_q <= 1'b0;
      end else begin
         done_q <= 1'b0;

         if (i_pc_load)
            pc_q <= i_pc_addr;
         else if (w_push)
            pc_q <= pc_q + ADDR_W'(1);

         case (state_q)
            ST_IDLE: begin
               discard_q <= 1'b0;
               // done_q guards against re-issuing the request still held
               // high during its own completion cycle.
               if (i_acc_req && !done_q) begin
                  state_q <= ST_DATA;
                  addr_q  <= i_acc_addr;
                  wdata_q <= i_acc_wdata;
                  if (i_acc_we)
                     we_n_q <= 1'b0;
                  else if (i_acc_psen)
                     psen_n_q <= 1'b0;
                  else
                     rd_n_q <= 1'b0;
               end else if (!i_pc_load && w_pf_room) begin
                  state_q  <= ST_FETCH;
                  addr_q   <= pc_q;
                  psen_n_q <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (i_pc_load)
                  discard_q <= 1'b1;
               if (w_complete) begin
                  state_q   <= ST_IDLE;
                  psen_n_q  <= 1'b1;
                  discard_q <= 1'b0;
               end
            end
            ST_DATA: begin
               if (w_complete) begin
                  state_q  <= ST_IDLE;
                  we_n_q   <= 1'b1;
                  rd_n_q   <= 1'b1;
                  psen_n_q <= 1'b1;
                  done_q   <= 1'b1;
                  rdata_q  <= w_cap_data;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef MC8051_BIU_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TO_CYC + 1);

   logic [WAIT_W-1:0] wait_q;
   logic              bus_err_q;

   // wait_q holds the number of strobe-low edges already seen without rdy;
   // the TO_CYC-th such edge completes the access instead.
   assign w_timeout = (state_q != ST_IDLE) && !mem_data_rdy &&
                      (wait_q == WAIT_W'(TO_CYC - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= w_timeout;
         if (state_q == ST_IDLE || w_complete)
            wait_q <= '0;
         else
            wait_q <= wait_q + WAIT_W'(1);
      end
   end

   assign o_bus_err = bus_err_q;
`else
   assign w_timeout = 1'b0;
   assign o_bus_err = 1'b0;
`endif

   mc8051_pfq #(
      .DEPTH  (PF_DEPTH),
      .DATA_W (DATA_W)
   ) u_pfq (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (w_push),
      .pop_i   (i_fetch_pop),
      .flush_i (i_pc_load),
      .data_i  (w_cap_data),
      .data_o  (o_fetch_data),
      .valid_o (o_fetch_valid),
      .count_o (w_pf_count)
   );

   assign mem_we_n    = we_n_q;
   assign mem_rd_n    = rd_n_q;
   assign mem_psen_n  = psen_n_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign o_acc_done  = done_q;
   assign o_acc_rdata = rdata_q;

endmodule
`default_nettype wire
